// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart_tx among N_REQ byte sources.
// One byte per transaction: accept in idle, launch pulse, wait for busy, wait for idle.
// Optional packet lock is built when UART_TX_ARB_LOCK_EN is defined; otherwise req_last is ignored.
//
// state    | meaning
// S_IDLE   | line free, choosing next requester (req_ready only here)
// S_LAUNCH | tx_en pulse for the byte just accepted
// S_WAITB  | waiting for uart_tx to raise busy (bounded by a guard count)
// S_WAITI  | frame in progress, waiting for busy to fall
module uart_tx_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_en,
    output logic [31:0]          tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAITB  = 2'd2,
        S_WAITI  = 2'd3
    } state_t;

    // Cycles spent in S_WAITB before giving up on a busy that never rises
    localparam logic [1:0] GUARD_LOAD = 2'd3;

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    idx;
    logic               found;
    logic               accept;
    logic [1:0]         guard_cnt;
    logic [N_REQ-1:0]   eligible;

`ifdef UART_TX_ARB_LOCK_EN
    logic               lock_on;
    logic [ID_W-1:0]    lock_id;

    // While a packet is open only its owner may be considered
    always_comb begin
        eligible = req_valid;
        if (lock_on) begin
            eligible = '0;
            eligible[lock_id] = req_valid[lock_id];
        end
    end

    // Open the lock on a non-final byte, close it on the final one
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_on <= 1'b0;
            lock_id <= '0;
        end else if (accept) begin
            lock_on <= !req_last[winner];
            lock_id <= winner;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign eligible    = req_valid;
`endif

    // First eligible requester after the last winner, wrapping at N_REQ
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign accept = (state == S_IDLE) && !tx_busy && found;
    assign active = (state != S_IDLE);

    // One-hot accept strobe toward the winning requester
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = S_WAITB;
            end
            S_WAITB: begin
                if (tx_busy) begin
                    state_nxt = S_WAITI;
                end else if (guard_cnt == 2'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            S_WAITI: begin
                if (!tx_busy) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Byte capture, launch pulse, round-robin pointer and busy guard timer
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= ID_W'(N_REQ - 1);
            tx_en     <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            guard_cnt <= '0;
        end else begin
            tx_en <= accept;
            if (accept) begin
                tx_data  <= {24'b0, req_data[8*winner +: 8]};
                grant_id <= winner;
                ptr      <= winner;
            end
            if (state == S_LAUNCH) begin
                guard_cnt <= GUARD_LOAD;
            end else if (state == S_WAITB && guard_cnt != 2'd0) begin
                guard_cnt <= guard_cnt - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: queue-based requesters, a behavioural uart_tx busy
// model and a round-robin / packet-lock reference model checked on every accept.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int FRAME = 10;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             tx_en;
    logic [31:0]      tx_data;
    logic             tx_busy;
    logic [1:0]       grant_id;
    logic             active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] mem [N][DEPTH];
    int         head [N];
    int         len  [N];
    logic [N-1:0] en_mask;
    bit         rand_en;

    int         last_grant;
    bit         lock_on;
    int         lock_id;

    int         busy_left;
    bit         raise_next;
    bit         no_busy_mode;
    bit         force_busy;

    bit         exp_tx_en;
    logic [31:0] exp_data;
    int         exp_gid;

    int         cycle;
    int         last_acc;
    int         glog [64];
    int         gcyc [64];
    int         n_log;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int model_winner();
        if (lock_on) return req_valid[lock_id] ? lock_id : -1;
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(last_grant + k) % N]) return (last_grant + k) % N;
        end
        return -1;
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (head[i] < len[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int i, input logic [7:0] b, input bit last);
        mem[i][len[i]] = {last, b};
        len[i]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            len[i]  = 0;
        end
        n_log = 0;
    endtask

    // One clock: check registered outputs, advance uart model, drive inputs, judge accept
    task automatic step();
        int w;
        logic [7:0] b;
        @(negedge clk);
        cycle++;
        chk("tx_en", tx_en, exp_tx_en);
        if (exp_tx_en) begin
            chk("tx_data", tx_data, exp_data);
            chk("grant_id", grant_id, exp_gid);
            chk("active_launch", active, 1);
        end
        if (!no_busy_mode) begin
            if (raise_next) begin
                busy_left  = FRAME;
                raise_next = 1'b0;
            end
            if (tx_en) raise_next = 1'b1;
        end
        tx_busy = force_busy;
        if (busy_left > 0) begin
            tx_busy = 1'b1;
            busy_left--;
        end
        if (rand_en) en_mask = N'($urandom);
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en_mask[i] && (head[i] < len[i]);
            b = 8'($urandom);
            req_last[i] = 1'($urandom);
            if (req_valid[i]) begin
                b = mem[i][head[i]][7:0];
                req_last[i] = mem[i][head[i]][8];
            end
            req_data[8*i +: 8] = b;
        end
        exp_tx_en = 1'b0;
        #1;
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
        if (req_ready != '0) begin
            w = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
            chk("ready_valid", req_valid[w], 1);
            chk("ready_busy", tx_busy, 0);
            chk("winner", w, model_winner());
            if (last_acc >= 0 && !no_busy_mode) chk("gap_min", 32'(cycle - last_acc >= FRAME + 3), 1);
            last_acc = cycle;
            if (n_log < 64) begin
                glog[n_log] = w;
                gcyc[n_log] = cycle;
                n_log++;
            end
            exp_tx_en = 1'b1;
            exp_data  = {24'b0, req_data[8*w +: 8]};
            exp_gid   = w;
            last_grant = w;
`ifdef UART_TX_ARB_LOCK_EN
            lock_on = !req_last[w];
            lock_id = w;
`endif
            if (head[w] < len[w]) head[w]++;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !(queues_empty() && busy_left == 0 && !raise_next &&
                               !active && !exp_tx_en)) begin
            step();
            n++;
        end
        chk("drain_done", 32'(n < budget), 1);
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        en_mask = '0;
        repeat (3) step();
        reset      = 1'b0;
        last_grant = N - 1;
        lock_on    = 1'b0;
        lock_id    = 0;
        last_acc   = -1;
        busy_left  = 0;
        raise_next = 1'b0;
        en_mask    = '1;
        clear_queues();
    endtask

    int e3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef UART_TX_ARB_LOCK_EN
    int e6 [5] = '{0, 0, 0, 1, 1};
`else
    int e6 [5] = '{0, 1, 0, 1, 0};
`endif

    initial begin
        int total;
        reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
        en_mask = '0; rand_en = 1'b0; no_busy_mode = 1'b0; force_busy = 1'b0;
        busy_left = 0; raise_next = 1'b0; exp_tx_en = 1'b0; exp_data = '0; exp_gid = 0;
        cycle = 0; last_acc = -1; last_grant = N - 1; lock_on = 1'b0; lock_id = 0;
        clear_queues();

        // Reset values, nothing requested
        apply_reset();
        chk("rst_ready", req_ready, 0);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_active", active, 0);
        repeat (8) begin
            step();
            chk("idle_active", active, 0);
            chk("idle_ready", req_ready, 0);
        end

        // Requester 2 alone sends 0x41
        push(2, 8'h41, 1'b1);
        drain(100);
        chk("single_count", n_log, 1);
        chk("single_id", glog[0], 2);
        chk("single_hold", tx_data, 32'h41);

        // All four continuously valid from reset: 0,1,2,3,0,... one per frame
        apply_reset();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
        drain(400);
        chk("rr_count", n_log, 8);
        for (int k = 0; k < 8; k++) begin
            chk("rr_order", glog[k], e3[k]);
            if (k > 0) chk("rr_gap", gcyc[k] - gcyc[k-1], FRAME + 3);
        end

        // Busy held high while idle blocks any accept
        clear_queues();
        force_busy = 1'b1;
        push(1, 8'h55, 1'b1);
        repeat (15) begin
            step();
            chk("busy_hold_ready", req_ready, 0);
        end
        force_busy = 1'b0;
        drain(100);
        chk("busy_rel_count", n_log, 1);
        chk("busy_rel_id", glog[0], 1);

        // Busy never rises: guard returns to idle and the next request is served
        clear_queues();
        no_busy_mode = 1'b1;
        push(3, 8'h33, 1'b1);
        push(0, 8'h30, 1'b1);
        drain(100);
        chk("guard_count", n_log, 2);
        chk("guard_first", glog[0], 3);
        chk("guard_second", glog[1], 0);
        chk("guard_gap", gcyc[1] - gcyc[0], 6);
        no_busy_mode = 1'b0;

        // Three-byte packet from 0 against single bytes from 1
        apply_reset();
        push(0, 8'h10, 1'b0);
        push(0, 8'h11, 1'b0);
        push(0, 8'h12, 1'b1);
        push(1, 8'h20, 1'b1);
        push(1, 8'h21, 1'b1);
        drain(300);
        chk("pkt_count", n_log, 5);
        for (int k = 0; k < 5; k++) chk("pkt_order", glog[k], e6[k]);

        // Randomized traffic with randomly gated valids
        for (int r = 0; r < 4; r++) begin
            clear_queues();
            total = 0;
            for (int i = 0; i < N; i++) begin
                int n;
                n = int'($urandom_range(0, 5));
                for (int j = 0; j < n; j++) push(i, 8'($urandom), (j == n - 1) ? 1'b1 : 1'($urandom));
                total += n;
            end
            rand_en = 1'b1;
            drain(3000);
            rand_en = 1'b0;
            en_mask = '1;
            chk("rand_count", n_log, total);
        end
        chk("end_active", active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
